pattern_stamper: RTL

// - Stamps an 8x8 preset pattern into the cell board at the cursor, upstream of life_logic's write port.
// - Takes a one-cycle stamp request from the user interface and reads the selected pattern from a ROM.
// - Issues one cell write per transfer over a valid/ready handshake into life_logic's write inputs.

---
 rtl/pattern_stamper_pkg.sv | 42 ++++
 rtl/pattern_stamper_if.sv | 34 +++
 rtl/pattern_stamper_rom.sv | 67 ++++++
 rtl/pattern_stamper.sv | 116 +++++++++++
 4 files changed

// File: rtl/pattern_stamper_pkg.sv
// Shared types for the pattern stamper.
// Positions, pattern ids, FSM states and wrap helpers.
package pattern_stamper_pkg;

  localparam int POS_W = 9;
  typedef logic [POS_W-1:0] pos_t;

  localparam int PATTERN_DIM  = 8;
  localparam int NUM_PATTERNS = 4;
  localparam int SEL_W        = $clog2(NUM_PATTERNS);

  typedef logic [SEL_W-1:0] pattern_sel_t;
  typedef logic [2:0]       idx_t;
  typedef logic [SEL_W+2:0] rom_addr_t;

  localparam pattern_sel_t PAT_GLIDER  = pattern_sel_t'(0);
  localparam pattern_sel_t PAT_BLINKER = pattern_sel_t'(1);
  localparam pattern_sel_t PAT_LWSS    = pattern_sel_t'(2);
  localparam pattern_sel_t PAT_RPENT   = pattern_sel_t'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_DONE
  } state_t;

  // base + off, folded once into [0, size); base must be < size
  function automatic pos_t wrap_add(pos_t base, idx_t off, pos_t size);
    logic [POS_W:0] sum;
    sum = {1'b0, base} + {{(POS_W-2){1'b0}}, off};
    if (sum >= {1'b0, size})
      sum = sum - {1'b0, size};
    return sum[POS_W-1:0];
  endfunction

  // clamp an out-of-board origin to the last row/column
  function automatic pos_t sat_pos(pos_t p, pos_t size);
    return (p >= size) ? size - pos_t'(1) : p;
  endfunction

endpackage

// File: rtl/pattern_stamper_if.sv
// Stamp request in, cell-write handshake out.
// master drives requests; slave is the stamper.
interface pattern_stamper_if;
  import pattern_stamper_pkg::*;

  logic         start_in;
  pattern_sel_t pattern_sel_in;
  pos_t         cursor_x_in;
  pos_t         cursor_y_in;
  logic         wr_ready_in;
  logic         wr_en_out;
  pos_t         wr_x_out;
  pos_t         wr_y_out;
  logic         alive_out;
  logic         busy_out;
  logic         done_out;

  modport master (
    output start_in, pattern_sel_in,
    output cursor_x_in, cursor_y_in,
    output wr_ready_in,
    input  wr_en_out, wr_x_out, wr_y_out,
    input  alive_out, busy_out, done_out
  );

  modport slave (
    input  start_in, pattern_sel_in,
    input  cursor_x_in, cursor_y_in,
    input  wr_ready_in,
    output wr_en_out, wr_x_out, wr_y_out,
    output alive_out, busy_out, done_out
  );

endinterface

// File: rtl/pattern_stamper_rom.sv
// 8x8 preset patterns, one row per address.
// Synchronous read, one cycle of latency; bit 7 is column 0.
module pattern_stamper_rom
  import pattern_stamper_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  rom_addr_t addr_in,
  output logic [7:0] data_out
);

  pattern_sel_t sel;
  idx_t         row;
  logic [7:0]   data_d;
  logic [7:0]   data_q;

  assign sel = addr_in[3 +: SEL_W];
  assign row = addr_in[2:0];

  // pattern table lookup
  always_comb begin
    data_d = 8'h00;
    case (sel)
      PAT_GLIDER: begin
        case (row)
          3'd0: data_d = 8'b0100_0000;
          3'd1: data_d = 8'b0010_0000;
          3'd2: data_d = 8'b1110_0000;
          default: data_d = 8'h00;
        endcase
      end
      PAT_BLINKER: begin
        case (row)
          3'd1: data_d = 8'b1110_0000;
          default: data_d = 8'h00;
        endcase
      end
      PAT_LWSS: begin
        case (row)
          3'd0: data_d = 8'b0100_1000;
          3'd1: data_d = 8'b1000_0000;
          3'd2: data_d = 8'b1000_1000;
          3'd3: data_d = 8'b1111_0000;
          default: data_d = 8'h00;
        endcase
      end
      PAT_RPENT: begin
        case (row)
          3'd0: data_d = 8'b0110_0000;
          3'd1: data_d = 8'b1100_0000;
          3'd2: data_d = 8'b0100_0000;
          default: data_d = 8'h00;
        endcase
      end
      default: data_d = 8'h00;
    endcase
  end

  // registered read port
  always_ff @(posedge clk_in) begin
    if (rst_in) data_q <= 8'h00;
    else        data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: rtl/pattern_stamper.sv
// Walks an 8x8 ROM pattern onto the board at the cursor.
// One cell write per valid/ready transfer, coordinates wrap.
module pattern_stamper
  import pattern_stamper_pkg::*;
#(
  parameter int BOARD_WIDTH  = 320,
  parameter int BOARD_HEIGHT = 240
) (
  input  logic clk_in,
  input  logic rst_in,
  pattern_stamper_if.slave bus
);

  localparam pos_t BW = pos_t'(BOARD_WIDTH);
  localparam pos_t BH = pos_t'(BOARD_HEIGHT);
  localparam idx_t LAST = idx_t'(PATTERN_DIM - 1);

  state_t       state_q;
  pattern_sel_t sel_q;
  pos_t         x0_q;
  pos_t         y0_q;
  idx_t         row_q;
  idx_t         col_q;
  logic         wr_en_q;
  pos_t         wr_x_q;
  pos_t         wr_y_q;
  logic         done_q;

  logic [7:0]   rom_row;
  idx_t         col_d;
  pos_t         x_d;
  pos_t         y_d;
  logic         xfer;
  logic         last_col;
  logic         last_row;

  pattern_stamper_rom u_rom (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .addr_in  ({sel_q, row_q}),
    .data_out (rom_row)
  );

  assign xfer     = wr_en_q & bus.wr_ready_in;
  assign last_col = (col_q == LAST);
  assign last_row = (row_q == LAST);
  assign col_d    = col_q + 3'd1;
  assign x_d      = wrap_add(x0_q, col_d, BW);
  assign y_d      = wrap_add(y0_q, row_q, BH);

  // stamp sequencer: fetch a row, write its 8 cells, repeat
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wr_en_q <= 1'b0;
      wr_x_q  <= '0;
      wr_y_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_in) begin
            sel_q   <= bus.pattern_sel_in;
            x0_q    <= sat_pos(bus.cursor_x_in, BW);
            y0_q    <= sat_pos(bus.cursor_y_in, BH);
            row_q   <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          col_q   <= '0;
          wr_en_q <= 1'b1;
          wr_x_q  <= x0_q;
          wr_y_q  <= y_d;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (xfer) begin
            if (!last_col) begin
              col_q  <= col_d;
              wr_x_q <= x_d;
            end else begin
              wr_en_q <= 1'b0;
              if (!last_row) begin
                row_q   <= row_q + 3'd1;
                state_q <= ST_FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_en_out = wr_en_q;
  assign bus.wr_x_out  = wr_x_q;
  assign bus.wr_y_out  = wr_y_q;
  assign bus.alive_out = wr_en_q & rom_row[3'd7 - col_q];
  assign bus.busy_out  = (state_q != ST_IDLE);
  assign bus.done_out  = done_q;

endmodule
